// File: rtl/window_3x3_gen_if.sv
// rtl/window_3x3_gen_if.sv - pixel stream in, 3x3 window and frame status out
interface window_3x3_gen_if;
  logic [7:0]  pix;
  logic        pix_en;
  logic [9:0]  row;
  logic [9:0]  col;
  logic [71:0] win;
  logic        win_valid;
  logic [9:0]  ctr_row;
  logic [9:0]  ctr_col;
  logic        frame_done;
  logic        sync_err;

  modport master (
    output pix, pix_en, row, col,
    input  win, win_valid, ctr_row, ctr_col, frame_done, sync_err
  );

  modport slave (
    input  pix, pix_en, row, col,
    output win, win_valid, ctr_row, ctr_col, frame_done, sync_err
  );
endinterface

// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - two-line-buffer 3x3 window generator with frame sync tracking
module window_3x3_gen #(
  parameter int MAX_ROW = 540,
  parameter int MAX_COL = 540
) (
  input logic               clk,
  input logic               rst_n,
  window_3x3_gen_if.slave   bus
);
  localparam int         AW       = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
  localparam logic [9:0] LAST_COL = 10'(MAX_COL - 1);
  localparam logic [9:0] LAST_ROW = 10'(MAX_ROW - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t      state, state_nxt;
  logic [9:0]  exp_row, exp_col, exp_row_nxt, exp_col_nxt;
  logic        take, mismatch, at_origin, at_exp, last_col, last_row, win_ok, eof;

  logic [7:0]  lb0 [MAX_COL];
  logic [7:0]  lb1 [MAX_COL];
  logic [7:0]  lb0_rd, lb1_rd;
  logic [AW-1:0] cidx;

  logic [71:0] win_q;
  logic        win_valid_q, frame_done_q, sync_err_q;
  logic [9:0]  ctr_row_q, ctr_col_q;

  assign cidx      = bus.col[AW-1:0];
  assign lb0_rd    = lb0[cidx];
  assign lb1_rd    = lb1[cidx];
  assign at_origin = (bus.row == 10'd0) && (bus.col == 10'd0);
  assign at_exp    = (bus.row == exp_row) && (bus.col == exp_col);
  assign last_col  = (bus.col == LAST_COL);
  assign last_row  = (bus.row == LAST_ROW);

  always_comb begin
    state_nxt   = state;
    exp_row_nxt = exp_row;
    exp_col_nxt = exp_col;
    take        = 1'b0;
    mismatch    = 1'b0;
    if (bus.pix_en) begin
      if (state == IDLE) begin
        take = at_origin;
        if (at_origin) state_nxt = FILL;
      end else if (!at_exp) begin
        // A desynchronised (0,0) doubles as a fresh frame start
        mismatch  = 1'b1;
        take      = at_origin;
        state_nxt = at_origin ? FILL : IDLE;
      end else begin
        take = 1'b1;
        if (state == FILL && bus.row == 10'd1 && last_col) state_nxt = RUN;
        if (state == RUN && last_row && last_col)          state_nxt = IDLE;
      end
      if (take) begin
        exp_col_nxt = last_col ? 10'd0 : bus.col + 10'd1;
        exp_row_nxt = last_col ? (last_row ? 10'd0 : bus.row + 10'd1) : bus.row;
      end
    end
  end

  assign win_ok = take && (state == RUN) && (bus.row >= 10'd2) && (bus.col >= 10'd2);
  assign eof    = take && !mismatch && (state == RUN) && last_row && last_col;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      exp_row      <= 10'd0;
      exp_col      <= 10'd0;
      win_q        <= 72'd0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      ctr_row_q    <= 10'd0;
      ctr_col_q    <= 10'd0;
    end else begin
      state        <= state_nxt;
      exp_row      <= exp_row_nxt;
      exp_col      <= exp_col_nxt;
      win_valid_q  <= win_ok;
      frame_done_q <= eof;
      sync_err_q   <= sync_err_q | mismatch;
      if (take) begin
        // Each window row shifts left; the new right column is {lb1, lb0, pix} top to bottom
        win_q <= {bus.pix, win_q[71:56], lb0_rd, win_q[47:32], lb1_rd, win_q[23:8]};
      end
      if (win_ok) begin
        ctr_row_q <= bus.row - 10'd1;
        ctr_col_q <= bus.col - 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      lb1[cidx] <= lb0_rd;
      lb0[cidx] <= bus.pix;
    end
  end

  assign bus.win        = win_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.ctr_row    = ctr_row_q;
  assign bus.ctr_col    = ctr_col_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb/tb_window_3x3_gen.sv - randomized/directed bench for window_3x3_gen on a 5x5 frame
module tb_window_3x3_gen;
  localparam int NR = 5;
  localparam int NC = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_3x3_gen_if bus ();

  window_3x3_gen #(.MAX_ROW(NR), .MAX_COL(NC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the frame image as seen so far plus the expected raster position
  logic [7:0]  img [NR][NC];
  bit          in_frame = 0;
  bit          m_err = 0;
  int          er = 0, ec = 0;

  int          valid_cnt = 0, done_cnt = 0, acc_cnt = 0, last_done_acc = 0, done_gap = 0;
  logic [71:0] obs_q [$];
  logic [71:0] first_win;
  logic [9:0]  first_cr, first_cc;
  bit          first_seen = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] p, input bit en, input int r, input int c, input bit rst = 1'b1);
    bit m_valid = 0, m_done = 0;
    logic [71:0] m_win = '0;
    int m_cr = 0, m_cc = 0;
    bit accept = 0;
    rst_n      = rst;
    bus.pix    = p;
    bus.pix_en = en;
    bus.row    = 10'(r);
    bus.col    = 10'(c);
    if (!rst) begin
      in_frame = 0;
      m_err    = 0;
    end else if (en) begin
      if (in_frame && !(r == er && c == ec)) begin
        m_err    = 1;
        in_frame = 0;
      end
      if (in_frame) accept = 1;
      else if (r == 0 && c == 0) begin
        in_frame = 1;
        accept   = 1;
      end
      if (accept) begin
        img[r][c] = p;
        if (r >= 2 && c >= 2) begin
          m_valid = 1;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              m_win[8*(3*i+j) +: 8] = img[r-2+i][c-2+j];
          m_cr = r - 1;
          m_cc = c - 1;
        end
        if (r == NR-1 && c == NC-1) begin
          m_done   = 1;
          in_frame = 0;
        end
        ec = (c + 1) % NC;
        er = (c == NC-1) ? (r + 1) % NR : r;
      end
    end
    @(posedge clk);
    #1;
    if (en && rst) acc_cnt++;
    if (!rst) begin
      chk("rst_win", bus.win, 72'd0);
      chk("rst_ctr", {52'd0, bus.ctr_row, bus.ctr_col}, 72'd0);
    end
    chk("win_valid", {71'd0, bus.win_valid}, {71'd0, m_valid});
    chk("frame_done", {71'd0, bus.frame_done}, {71'd0, m_done});
    chk("sync_err", {71'd0, bus.sync_err}, {71'd0, m_err});
    if (m_valid) begin
      chk("win", bus.win, m_win);
      chk("ctr_row", {62'd0, bus.ctr_row}, 72'(m_cr));
      chk("ctr_col", {62'd0, bus.ctr_col}, 72'(m_cc));
    end
    if (bus.win_valid === 1'b1) begin
      valid_cnt++;
      obs_q.push_back(bus.win);
      if (!first_seen) begin
        first_seen = 1;
        first_win  = bus.win;
        first_cr   = bus.ctr_row;
        first_cc   = bus.ctr_col;
      end
    end
    if (bus.frame_done === 1'b1) begin
      done_cnt++;
      done_gap      = acc_cnt - last_done_acc;
      last_done_acc = acc_cnt;
    end
    bus.pix_en = 1'b0;
  endtask

  // Sends raster positions k0..k1 (k = row*NC + col)
  task automatic frame(input int k0, input int k1, input bit gaps, input bit ramp);
    for (int k = k0; k <= k1; k++) begin
      int r = k / NC;
      int c = k % NC;
      if (gaps) begin
        int n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) cyc(8'($urandom), 1'b0, $urandom_range(0, 4), $urandom_range(0, 4));
      end
      cyc(ramp ? 8'(10*r + c) : 8'($urandom), 1'b1, r, c);
    end
  endtask

  logic [71:0] ref_q [$];

  initial begin
    bus.pix = '0; bus.pix_en = 1'b0; bus.row = '0; bus.col = '0;
    cyc(8'd0, 1'b0, 0, 0, 1'b0);
    cyc(8'd0, 1'b0, 0, 0, 1'b0);

    // Golden ramp frame, continuous strobe
    obs_q.delete(); valid_cnt = 0; done_cnt = 0;
    frame(0, 24, 1'b0, 1'b1);
    cyc(8'd0, 1'b0, 0, 0);
    chk("first_win", first_win, 72'h16_15_14_0C_0B_0A_02_01_00);
    chk("first_ctr", {52'd0, first_cr, first_cc}, {52'd0, 10'd1, 10'd1});
    chk("valid_cnt_golden", 72'(valid_cnt), 72'd9);
    chk("done_cnt_golden", 72'(done_cnt), 72'd1);
    ref_q = obs_q;

    // Same frame with random idle cycles between pixels
    obs_q.delete(); valid_cnt = 0;
    frame(0, 24, 1'b1, 1'b1);
    chk("valid_cnt_gaps", 72'(valid_cnt), 72'd9);
    for (int i = 0; i < 9; i++)
      chk("gap_seq", (i < obs_q.size()) ? obs_q[i] : 72'hx, ref_q[i]);

    // Random pixel frames back to back: done pulses 25 acceptances apart
    done_cnt = 0;
    frame(0, 24, 1'b0, 1'b0);
    frame(0, 24, 1'b0, 1'b0);
    chk("b2b_done_cnt", 72'(done_cnt), 72'd2);
    chk("b2b_done_gap", 72'(done_gap), 72'd25);

    // Skipped pixel (2,3): error is sticky, no windows until a new frame
    frame(0, 12, 1'b0, 1'b0);
    cyc(8'($urandom), 1'b1, 2, 4);
    chk("skip_err", {71'd0, bus.sync_err}, 72'd1);
    valid_cnt = 0;
    frame(15, 24, 1'b1, 1'b0);
    chk("skip_no_valid", 72'(valid_cnt), 72'd0);
    frame(0, 24, 1'b1, 1'b0);
    chk("skip_recover_cnt", 72'(valid_cnt), 72'd9);
    chk("skip_err_sticky", {71'd0, bus.sync_err}, 72'd1);

    // Reset, then stream begins mid-frame at (3,1)
    cyc(8'd0, 1'b0, 0, 0, 1'b0);
    valid_cnt = 0;
    frame(16, 24, 1'b0, 1'b0);
    chk("midframe_no_valid", 72'(valid_cnt), 72'd0);
    chk("midframe_no_err", {71'd0, bus.sync_err}, 72'd0);
    frame(0, 24, 1'b1, 1'b0);
    chk("midframe_recover_cnt", 72'(valid_cnt), 72'd9);

    // Reset asserted at pixel (3,3), then a full golden frame
    frame(0, 17, 1'b0, 1'b1);
    cyc(8'd33, 1'b1, 3, 3, 1'b0);
    obs_q.delete(); valid_cnt = 0;
    frame(0, 24, 1'b0, 1'b1);
    chk("post_rst_cnt", 72'(valid_cnt), 72'd9);
    for (int i = 0; i < 9; i++)
      chk("post_rst_seq", (i < obs_q.size()) ? obs_q[i] : 72'hx, ref_q[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
